// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the command-driven SPI master: command encodings,
// frame geometry and the controller state type.
package spi_master_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    CAPTURE,
    GAP
  } state_t;

  // Bit 10 duplicates cmd_type[1] so the slave sees its read/write select first.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [1:0] i_type,
                                                       input logic [DATA_BITS-1:0] i_data);
    return {i_type[1], i_type, i_data};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_shift_reg.sv
// Loadable MSB-first shift register with serial input; load wins over shift.
module spi_shift_reg
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = FRAME_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], i_sin};
    end
  end

  assign o_data = r_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one host command becomes one SS_n-framed transaction; read-data
// frames capture an 8-bit reply from MISO after a turnaround window.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned IDLE_GAP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_BITS - 1);
  localparam logic [3:0] TA_LOAD    = 4'(TURNAROUND - 1);
  localparam logic [3:0] CAP_LOAD   = 4'(DATA_BITS - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(IDLE_GAP - 1);
  localparam logic [3:0] GAP_RST    = 4'(IDLE_GAP);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_is_read;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_ssn;
  logic                  r_rsp_valid;
  logic [DATA_BITS-1:0]  r_rsp_data;

  logic                  w_accept;
  logic [FRAME_BITS-1:0] w_frame;
  logic [FRAME_BITS-1:0] w_out_q;
  logic [FRAME_BITS-1:0] w_in_q;
  logic [DATA_BITS-1:0]  w_rsp_next;
  logic                  w_unused;

  assign w_accept   = (r_state == IDLE) && r_ready && cmd_valid;
  assign w_frame    = frame_word(cmd_type, cmd_data);
  assign w_rsp_next = {w_in_q[DATA_BITS-2:0], MISO};
  assign w_unused   = &{1'b0, w_out_q[FRAME_BITS-2:0], w_in_q[FRAME_BITS-1:DATA_BITS-1]};

  // Zeros shift in behind the frame, so MOSI idles low once the word is out.
  spi_shift_reg #(.WIDTH(FRAME_BITS)) u_mosi_sr (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_data (w_frame),
    .i_shift     (r_state == SHIFT),
    .i_sin       (1'b0),
    .o_data      (w_out_q)
  );

  spi_shift_reg #(.WIDTH(FRAME_BITS)) u_miso_sr (
    .clk         (clk),
    .rst         (rst),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (r_state == CAPTURE),
    .i_sin       (MISO),
    .o_data      (w_in_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= GAP_RST;
      r_is_read   <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_ssn       <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= SHIFT;
            r_cnt     <= SHIFT_LOAD;
            r_is_read <= (cmd_t'(cmd_type) == CMD_RD_DATA);
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_ssn     <= 1'b0;
          end else if (!r_ready) begin
            if (r_cnt <= 4'd1) r_ready <= 1'b1;
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          end
        end
        SHIFT: begin
          if (r_cnt == 4'd0) begin
            if (r_is_read) begin
              r_state <= WAIT;
              r_cnt   <= TA_LOAD;
            end else begin
              r_state <= GAP;
              r_cnt   <= GAP_LOAD;
              r_ssn   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= CAPTURE;
            r_cnt   <= CAP_LOAD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        CAPTURE: begin
          // The 8th MISO bit is folded in directly so the reply lands as SS_n rises.
          if (r_cnt == 4'd0) begin
            r_state     <= GAP;
            r_cnt       <= GAP_LOAD;
            r_ssn       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rsp_next;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        GAP: begin
          if (r_cnt == 4'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign SS_n      = r_ssn;
  assign MOSI      = w_out_q[FRAME_BITS-1];
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
